// File: rtl/isp_stream_pkg.sv
// Shared definitions for the raw Bayer streaming front end: the streamer state
// encoding and the default frame geometry.
package isp_stream_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_NEWF   = 3'd1,
    ST_LEAD   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_HBL    = 3'd4,
    ST_FLUSH  = 3'd5,
    ST_FBL    = 3'd6
  } stream_state_e;

  localparam int DEF_WIDTH    = 320;
  localparam int DEF_HEIGHT   = 240;
  localparam int DEF_LEAD_GAP = 32;
  localparam int DEF_HBLANK   = 16;

  // Counter width for a terminal count of n, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gap_counter.sv
// Loadable down-counter that stops at zero; tc flags the final cycle of a
// timed interval loaded with (duration - 1).
module gap_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: load wins, otherwise count down and hold at zero.
  always_comb begin
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != {W{1'b0}}) begin
      cnt_d = cnt_q - 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/bayer_stream_tx.sv
// Streams one raw Bayer frame per start request into the processing pipeline,
// inserting lead-in and row blanking, then zero flush rows until it drains.
module bayer_stream_tx
  import isp_stream_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int HEIGHT   = DEF_HEIGHT,
  parameter int LEAD_GAP = DEF_LEAD_GAP,
  parameter int HBLANK   = DEF_HBLANK
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       sValid,
  input  logic [7:0] sData,
  output logic       sReady,
  output logic       newFrame,
  output logic       oValid,
  output logic [7:0] oData,
  input  logic       flushDone,
  output logic       busy,
  output logic       frameDone
);

  localparam int CW = cnt_width(WIDTH);
  localparam int RW = cnt_width(HEIGHT);
  localparam int GW = cnt_width((LEAD_GAP > HBLANK) ? LEAD_GAP : HBLANK);

  localparam logic [CW-1:0] COL_LAST  = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(HEIGHT - 1);
  localparam logic [GW-1:0] LEAD_LOAD = GW'(LEAD_GAP - 2);
  localparam logic [GW-1:0] HBL_LOAD  = GW'(HBLANK - 1);

  stream_state_e state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          last_row_q, last_row_d;
  logic          done_seen_q, done_seen_d;
  logic          flush_go_q, flush_go_d;
  logic          new_frame_q, new_frame_d;
  logic          ovalid_q, ovalid_d;
  logic [7:0]    odata_q, odata_d;
  logic          busy_q, busy_d;
  logic          frame_done_q, frame_done_d;
  logic          gap_load;
  logic [GW-1:0] gap_val;
  logic          gap_tc;
  logic          accept;
  logic          done_window;

  assign sReady      = (state_q == ST_ACTIVE);
  assign accept      = sValid & sReady;
  assign done_window = ((state_q == ST_HBL) && last_row_q) ||
                       (state_q == ST_FLUSH) || (state_q == ST_FBL);

  gap_counter #(.W(GW)) u_gap (
    .clk      (clk),
    .reset    (reset),
    .load     (gap_load),
    .load_val (gap_val),
    .tc       (gap_tc)
  );

  // Next-state, counter and output decode.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    last_row_d   = last_row_q;
    flush_go_d   = flush_go_q;
    new_frame_d  = 1'b0;
    ovalid_d     = 1'b0;
    odata_d      = 8'd0;
    frame_done_d = 1'b0;
    gap_load     = 1'b0;
    gap_val      = {GW{1'b0}};
    if (done_window && flushDone) begin
      done_seen_d = 1'b1;
    end else begin
      done_seen_d = done_seen_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_NEWF;
        else       state_d = ST_IDLE;
      end
      ST_NEWF: begin
        new_frame_d = 1'b1;
        done_seen_d = 1'b0;
        col_d       = {CW{1'b0}};
        row_d       = {RW{1'b0}};
        last_row_d  = 1'b0;
        flush_go_d  = 1'b0;
        gap_load    = 1'b1;
        gap_val     = LEAD_LOAD;
        state_d     = ST_LEAD;
      end
      ST_LEAD: begin
        if (gap_tc) state_d = ST_ACTIVE;
        else        state_d = ST_LEAD;
      end
      ST_ACTIVE: begin
        if (accept) begin
          ovalid_d = 1'b1;
          odata_d  = sData;
          if (col_q == COL_LAST) begin
            col_d    = {CW{1'b0}};
            gap_load = 1'b1;
            gap_val  = HBL_LOAD;
            state_d  = ST_HBL;
            if (row_q == ROW_LAST) begin
              row_d      = {RW{1'b0}};
              last_row_d = 1'b1;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end else begin
          ovalid_d = 1'b0;
        end
      end
      ST_HBL: begin
        if (gap_tc) begin
          state_d    = last_row_q ? ST_FLUSH : ST_ACTIVE;
          flush_go_d = 1'b0;
        end else begin
          state_d = ST_HBL;
        end
      end
      // First FLUSH cycle is idle; col then counts the WIDTH zero pixels.
      ST_FLUSH: begin
        if (!flush_go_q) begin
          flush_go_d = 1'b1;
        end else begin
          ovalid_d = 1'b1;
          if (col_q == COL_LAST) begin
            col_d      = {CW{1'b0}};
            flush_go_d = 1'b0;
            if (done_seen_d) begin
              state_d      = ST_IDLE;
              frame_done_d = 1'b1;
            end else begin
              state_d  = ST_FBL;
              gap_load = 1'b1;
              gap_val  = HBL_LOAD;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      ST_FBL: begin
        if (gap_tc) state_d = ST_FLUSH;
        else        state_d = ST_FBL;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      col_q        <= {CW{1'b0}};
      row_q        <= {RW{1'b0}};
      last_row_q   <= 1'b0;
      done_seen_q  <= 1'b0;
      flush_go_q   <= 1'b0;
      new_frame_q  <= 1'b0;
      ovalid_q     <= 1'b0;
      odata_q      <= 8'd0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      last_row_q   <= last_row_d;
      done_seen_q  <= done_seen_d;
      flush_go_q   <= flush_go_d;
      new_frame_q  <= new_frame_d;
      ovalid_q     <= ovalid_d;
      odata_q      <= odata_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign newFrame  = new_frame_q;
  assign oValid    = ovalid_q;
  assign oData     = odata_q;
  assign busy      = busy_q;
  assign frameDone = frame_done_q;

endmodule

// File: tb/tb_bayer_stream_tx.sv
// Self-checking bench for bayer_stream_tx: a timeline model predicts every
// output cycle of a frame from the source valid pattern and flush-done timing.
module tb_bayer_stream_tx;

  localparam int W    = 4;
  localparam int H    = 2;
  localparam int LG   = 4;
  localparam int HB   = 2;
  localparam int MAXT = 512;

  logic       clk = 1'b0;
  logic       reset, start, sValid, flushDone;
  logic [7:0] sData;
  logic       sReady, newFrame, oValid, busy, frameDone;
  logic [7:0] oData;

  int n_vec = 0;
  int n_err = 0;

  bit         sv_pat [MAXT];
  logic [7:0] pix    [W*H];
  bit         exp_v  [MAXT];
  logic [7:0] exp_d  [MAXT];
  bit         exp_r  [MAXT];
  int         fd_rel, fdn_rel, n_flush;

  always #5 clk = ~clk;

  bayer_stream_tx #(.WIDTH(W), .HEIGHT(H), .LEAD_GAP(LG), .HBLANK(HB)) dut (
    .clk(clk), .reset(reset), .start(start), .sValid(sValid), .sData(sData),
    .sReady(sReady), .newFrame(newFrame), .oValid(oValid), .oData(oData),
    .flushDone(flushDone), .busy(busy), .frameDone(frameDone)
  );

  // Timeline relative to the newFrame cycle (t=0). Pixels are accepted from
  // t=LG-1 whenever the source is valid; each row is followed by HB blank
  // cycles; each flush row is 1 idle cycle then W zero pixels (seen one cycle
  // later on the output), separated by HB blank cycles. done_row>=0 pulses
  // flushDone inside that flush row, done_row<0 pulses it in the first blank
  // cycle after the last image row.
  task automatic build_model(input int done_row);
    int t, f;
    for (int i = 0; i < MAXT; i++) begin
      exp_v[i] = 1'b0; exp_d[i] = 8'd0; exp_r[i] = 1'b0;
    end
    fdn_rel = MAXT;
    t = LG - 1;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        while (!sv_pat[t] && t < MAXT - 100) begin
          exp_r[t] = 1'b1;
          t++;
        end
        exp_r[t]   = 1'b1;
        exp_v[t+1] = 1'b1;
        exp_d[t+1] = pix[r*W + c];
        t++;
      end
      if (r == H - 1 && done_row < 0) fdn_rel = t;
      t += HB;
    end
    f = t;
    n_flush = 0;
    for (int k = 0; k < 8; k++) begin
      if (k == done_row) fdn_rel = f + 2;
      for (int i = 1; i <= W; i++) exp_v[f+1+i] = 1'b1;
      n_flush++;
      if (f + W >= fdn_rel) begin
        fd_rel = f + W + 1;
        break;
      end
      f = f + W + 1 + HB;
    end
  endtask

  task automatic fill_pix(input bit seq);
    for (int i = 0; i < W*H; i++) pix[i] = seq ? 8'(i + 1) : 8'($urandom_range(0, 255));
  endtask

  task automatic fill_sv(input bit rnd);
    for (int i = 0; i < MAXT; i++) sv_pat[i] = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
  endtask

  // Run one modelled frame; abort_at>=0 asserts reset at that cycle instead.
  task automatic run_frame(input bit pre_started, input bit hold, input bit noise,
                           input int abort_at, input string name);
    int cnt;
    cnt = 0;
    if (!pre_started) begin
      @(negedge clk);
      start = 1'b1;
    end
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b1 || newFrame !== 1'b0 || oValid !== 1'b0) begin
      n_err++;
      $display("FAIL %s newf_cycle busy/newFrame/oValid got %b%b%b want 100", name, busy, newFrame, oValid);
    end
    start = hold;
    sValid = 1'b0;
    flushDone = 1'b0;
    for (int t = 0; t <= fd_rel; t++) begin
      @(negedge clk);
      if (t == abort_at) begin
        #2 reset = 1'b0;
        #1;
        n_vec++;
        if ({oValid, oData, newFrame, busy, frameDone, sReady} !== 13'd0) begin
          n_err++;
          $display("FAIL %s async_reset outputs got %b want 0", name,
                   {oValid, oData, newFrame, busy, frameDone, sReady});
        end
        sValid = 1'b0; flushDone = 1'b0; start = 1'b0;
        for (int i = 0; i < 2; i++) begin
          @(negedge clk);
          n_vec++;
          if (frameDone !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s in_reset frameDone/busy got %b%b want 00", name, frameDone, busy);
          end
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          n_vec++;
          if (frameDone !== 1'b0 || busy !== 1'b0 || newFrame !== 1'b0 || oValid !== 1'b0) begin
            n_err++;
            $display("FAIL %s post_reset_idle got fd=%b busy=%b nf=%b ov=%b want 0", name,
                     frameDone, busy, newFrame, oValid);
          end
        end
        return;
      end
      n_vec++;
      if (oValid !== exp_v[t]) begin
        n_err++;
        $display("FAIL %s oValid t=%0d got %b want %b", name, t, oValid, exp_v[t]);
      end
      if (exp_v[t]) begin
        n_vec++;
        if (oData !== exp_d[t]) begin
          n_err++;
          $display("FAIL %s oData t=%0d got %0d want %0d", name, t, oData, exp_d[t]);
        end
      end
      n_vec++;
      if (sReady !== exp_r[t]) begin
        n_err++;
        $display("FAIL %s sReady t=%0d got %b want %b", name, t, sReady, exp_r[t]);
      end
      n_vec++;
      if (newFrame !== (t == 0)) begin
        n_err++;
        $display("FAIL %s newFrame t=%0d got %b want %b", name, t, newFrame, (t == 0));
      end
      n_vec++;
      if (frameDone !== (t == fd_rel)) begin
        n_err++;
        $display("FAIL %s frameDone t=%0d got %b want %b", name, t, frameDone, (t == fd_rel));
      end
      n_vec++;
      if (busy !== (t < fd_rel)) begin
        n_err++;
        $display("FAIL %s busy t=%0d got %b want %b", name, t, busy, (t < fd_rel));
      end
      sValid = sv_pat[t];
      if (sv_pat[t] && cnt < W*H) sData = pix[cnt];
      else                        sData = 8'($urandom_range(0, 255));
      if (exp_r[t] && sv_pat[t]) cnt++;
      flushDone = (t == fdn_rel) || (noise && (t == 1 || t == LG));
      start     = hold || (noise && t == LG + 1);
    end
    sValid = 1'b0;
    flushDone = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; sValid = 1'b0; sData = 8'd0; flushDone = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({oValid, oData, newFrame, busy, frameDone, sReady} !== 13'd0) begin
      n_err++;
      $display("FAIL reset_state outputs got %b want 0", {oValid, oData, newFrame, busy, frameDone, sReady});
    end
    reset = 1'b1;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || newFrame !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_reset busy/newFrame got %b%b want 00", busy, newFrame);
    end
  endtask

  task automatic test_basic();
    fill_pix(1'b1); fill_sv(1'b0); build_model(0);
    run_frame(1'b0, 1'b0, 1'b0, -1, "basic");
  endtask

  task automatic test_svalid_gap();
    fill_pix(1'b1); fill_sv(1'b0);
    for (int i = 0; i < 3; i++) sv_pat[LG + 1 + i] = 1'b0;
    build_model(0);
    run_frame(1'b0, 1'b0, 1'b0, -1, "sgap");
  endtask

  task automatic test_flush_rows();
    fill_pix(1'b0); fill_sv(1'b0); build_model(2);
    n_vec++;
    if (n_flush !== 3) begin
      n_err++;
      $display("FAIL flush3 model_rows got %0d want 3", n_flush);
    end
    run_frame(1'b0, 1'b0, 1'b1, -1, "flush3");
  endtask

  task automatic test_done_in_hbl();
    fill_pix(1'b0); fill_sv(1'b0); build_model(-1);
    run_frame(1'b0, 1'b0, 1'b0, -1, "done_hbl");
  endtask

  task automatic test_back_to_back();
    fill_pix(1'b0); fill_sv(1'b1); build_model(1);
    run_frame(1'b0, 1'b1, 1'b0, -1, "b2b_a");
    fill_pix(1'b0); fill_sv(1'b1); build_model(0);
    run_frame(1'b1, 1'b0, 1'b0, -1, "b2b_b");
  endtask

  task automatic test_reset_mid_frame();
    fill_pix(1'b1); fill_sv(1'b0); build_model(0);
    run_frame(1'b0, 1'b0, 1'b0, LG - 1 + W + HB + 2, "rst_mid");
    fill_pix(1'b0); fill_sv(1'b0); build_model(0);
    run_frame(1'b0, 1'b0, 1'b0, -1, "after_rst");
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      fill_pix(1'b0); fill_sv(1'b1);
      build_model($urandom_range(0, 3) - 1);
      run_frame(1'b0, 1'b0, 1'($urandom_range(0, 1)), -1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_svalid_gap();
    test_flush_rows();
    test_done_in_hbl();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/bayer_stream_tx.md
BAYER_STREAM_TX -- requirements
Module: bayer_stream_tx

Interface
REQ-001 Parameter WIDTH, default 320: active pixels per row.
REQ-002 Parameter HEIGHT, default 240: active rows per frame.
REQ-003 Parameter LEAD_GAP, default 32: cycles from the newFrame pulse to the earliest first-pixel output.
REQ-004 Parameter HBLANK, default 16: output idle cycles after every row, including flush rows.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 reset  in  1  asynchronous, active-low (0 = in reset).
REQ-007 start  in  1  request to stream one frame; sampled only in IDLE.
REQ-008 sValid  in  1  source pixel available.
REQ-009 sData  in  8  source raw Bayer pixel, row-major, GBGB/RGRG order.
REQ-010 sReady  out  1  block accepts sData this cycle.
REQ-011 newFrame  out  1  one-cycle frame-start pulse to the processing pipeline.
REQ-012 oValid  out  1  oData valid.
REQ-013 oData  out  8  raw pixel to the pipeline.
REQ-014 flushDone  in  1  downstream pipeline drained (demosaic done).
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 frameDone  out  1  one-cycle pulse on entering IDLE from FLUSH.

Function
REQ-017 States: IDLE, NEWF, LEAD, ACTIVE, HBL, FLUSH, FBL; state, counters, and all outputs except sReady are registered.
REQ-018 IDLE: start=1 -> NEWF; otherwise hold; sReady=0, oValid=0.
REQ-019 NEWF: lasts 1 cycle; newFrame registered high for exactly 1 output cycle; -> LEAD.
REQ-020 LEAD: LEAD_GAP-1 cycles; -> ACTIVE, so the first oValid is no earlier than LEAD_GAP cycles after newFrame.
REQ-021 ACTIVE: sReady=1 (decoded from state); accept = sValid&sReady; on accept, oValid<=1 and oData<=sData (1-cycle latency); otherwise oValid<=0; sValid gaps are passed through as oValid=0 gaps, and no data is lost or duplicated.
REQ-022 Column counter increments on accept; on the accept of column WIDTH-1 it wraps to 0, the row counter increments, and the state -> HBL.
REQ-023 HBL: HBLANK cycles with sReady=0, giving exactly HBLANK output cycles of oValid=0 after the last pixel of a row; then -> ACTIVE if rows < HEIGHT, else -> FLUSH.
REQ-024 FLUSH: one idle cycle, then WIDTH consecutive cycles of oValid=1, oData=0, with sReady=0; then -> IDLE if done_seen, else -> FBL.
REQ-025 done_seen: sticky flag set by flushDone=1 in any cycle of HBL after the last row, FLUSH, or FBL; cleared in NEWF.
REQ-026 FBL: HBLANK cycles with oValid=0; -> FLUSH.
REQ-027 flushDone outside those states is ignored; start outside IDLE is ignored.
REQ-028 The FLUSH->IDLE transition fires frameDone for 1 cycle; start is accepted in the following cycle (back-to-back frames).
REQ-029 Counter widths are $clog2 of (WIDTH, HEIGHT, max(LEAD_GAP, HBLANK)) and have no overflow beyond their terminal counts.

Reset
REQ-030 While reset=0: state=IDLE, all counters=0, done_seen=0, and newFrame, oValid, oData, busy, frameDone = 0; sReady=0.
REQ-031 Reset asserted mid-frame aborts the frame with no frameDone; after release the block waits in IDLE for start.
REQ-032 Reset deassertion is synchronised externally; the block adds no reset synchroniser.

Structure
REQ-033 Shared package isp_stream_pkg holds the state enum and the default WIDTH/HEIGHT/LEAD_GAP/HBLANK constants.
REQ-034 One sub-module, gap_counter (loadable down-counter with a terminal-count flag), is used for the LEAD, HBL and FBL durations.

Verification (WIDTH=4, HEIGHT=2, LEAD_GAP=4, HBLANK=2 unless stated)
REQ-035 start pulse, sValid held 1, sData=1..8 -> newFrame at cycle N; oData 1,2,3,4 at N+4..N+7; oValid=0 at N+8,N+9; then oData 5..8.
REQ-036 sValid low for 3 cycles mid-row -> oValid gap of exactly 3 cycles; output sequence 1..8 still intact.
REQ-037 flushDone=1 during the first flush row -> one idle cycle plus 4 zero pixels, frameDone pulse, busy=0; flushDone held 0 until the third flush -> exactly 3 flush rows, each separated by 2 blank cycles.
REQ-038 start held 1 continuously -> second newFrame 1 cycle after frameDone; start pulsed while ACTIVE -> no effect.
REQ-039 reset=0 during row 2 -> all outputs 0 immediately (asynchronously); no frameDone; a new start after release streams a full frame.
REQ-040 Defaults 320x240 with random sValid -> 76800 pixels out, matching the input order, with 240 rows each followed by 16 blank cycles.
